// File: rtl/screen_sequencer.sv
// Game-level screen sequencer: turns game events into full-screen redraw
// requests and holds further redraws until the frame drawer finishes.
module screen_sequencer #(
  parameter int MAX_LEVEL   = 4,
  parameter int START_LIVES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_game,
  input  logic       life_lost,
  input  logic       level_complete,
  input  logic       draw_active,
  output logic       next,
  output logic [3:0] next_screen,
  output logic [2:0] level,
  output logic [1:0] lives,
  output logic       busy
);

  typedef enum logic [1:0] {S_ISSUE, S_ARM, S_WAIT, S_READY} state_t;
  typedef enum logic [1:0] {P_TITLE, P_PLAYING, P_OVER} phase_t;
  typedef enum logic [1:0] {E_NONE, E_START, E_LIFE, E_LEVEL} evt_t;

  localparam logic [2:0] MAX_LVL = 3'(MAX_LEVEL);
  localparam logic [1:0] LIVES0  = 2'(START_LIVES);

  state_t     state;
  phase_t     phase, phase_n;
  evt_t       evt, sel;
  logic [2:0] pend, legal, clr;
  logic [2:0] lvl_n;
  logic [1:0] lives_n;
  logic [3:0] lvl_m1, screen_n;

  // Effect of the selected event, applied when the redraw is issued
  always_comb begin
    lvl_n   = level;
    lives_n = lives;
    phase_n = phase;
    case (evt)
      E_START: begin
        lvl_n   = 3'd1;
        lives_n = LIVES0;
        phase_n = P_PLAYING;
      end
      E_LIFE: begin
        if (lives != 2'd0) lives_n = lives - 2'd1;
        if (lives <= 2'd1) phase_n = P_OVER;
      end
      E_LEVEL: begin
        if (level >= MAX_LVL) phase_n = P_OVER;
        else begin
          lvl_n   = level + 3'd1;
          lives_n = LIVES0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    lvl_m1 = {1'b0, lvl_n} - 4'd1;
    case (phase_n)
      P_PLAYING: screen_n = lvl_m1 + lvl_m1 + lvl_m1 + (4'd4 - {2'b00, lives_n});
      P_OVER:    screen_n = (lives_n == 2'd0) ? 4'd13 : 4'd14;
      default:   screen_n = 4'd0;
    endcase
  end

  // Latch order {level_complete, life_lost, start_game}; start only legal outside PLAYING
  always_comb begin
    legal = (phase == P_PLAYING) ? {pend[2], pend[1], 1'b0} : {2'b00, pend[0]};
    sel   = E_NONE;
    clr   = pend & ~legal;
    if (legal[0])      begin sel = E_START; clr[0] = 1'b1; end
    else if (legal[1]) begin sel = E_LIFE;  clr[1] = 1'b1; end
    else if (legal[2]) begin sel = E_LEVEL; clr[2] = 1'b1; end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_ISSUE;
      phase       <= P_TITLE;
      evt         <= E_NONE;
      pend        <= 3'b000;
      next        <= 1'b0;
      next_screen <= 4'd0;
      level       <= 3'd1;
      lives       <= LIVES0;
      busy        <= 1'b0;
    end else begin
      next <= 1'b0;
      if (state == S_READY)
        pend <= (pend & ~clr) | {level_complete, life_lost, start_game};
      else
        pend <= pend | {level_complete, life_lost, start_game};
      case (state)
        S_ISSUE: begin
          next        <= 1'b1;
          next_screen <= screen_n;
          level       <= lvl_n;
          lives       <= lives_n;
          phase       <= phase_n;
          busy        <= 1'b1;
          evt         <= E_NONE;
          state       <= S_ARM;
        end
        S_ARM: state <= S_WAIT;
        S_WAIT: begin
          if (!draw_active) begin
            busy  <= 1'b0;
            state <= S_READY;
          end
        end
        default: begin
          evt <= sel;
          if (sel != E_NONE) state <= S_ISSUE;
        end
      endcase
    end
  end

endmodule
